// File: rtl/crc16_par_check.sv
// Receive-side CRC-16 checker: strips the 2 trailing CRC bytes, forwards payload, reports status.
// Latency: payload byte n appears 1 cycle after byte n+2 is accepted; status is valid 1 cycle after the last byte.
// Backpressure: din_ready drops for the single status (DONE) cycle only; no downstream backpressure on dout.
module crc16_par_check #(
  parameter logic [15:0] POLY  = 16'h8005,
  parameter logic [15:0] INIT  = 16'h0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] frame_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      crc_reg;
  logic [15:0]      crc_base;
  logic [15:0]      crc_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       hold_new;
  logic [7:0]       hold_old;
  logic             accept;
  logic             first_byte;
  logic             fwd;
  logic             short_frame;

  // Eight MSB-first serial LFSR steps unrolled into one combinational stage.
  function automatic logic [15:0] next_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) begin
        r = r ^ POLY;
      end
    end
    return r;
  endfunction

  assign accept     = din_valid && din_ready;
  assign first_byte = (state == IDLE);

  // The first byte of a frame starts from INIT regardless of the leftover register value.
  assign crc_base   = first_byte ? INIT : crc_reg;
  assign crc_nxt    = next_crc(crc_base, din);

  // Byte count including the byte being accepted now; saturates instead of wrapping.
  assign count_nxt  = first_byte ? CNT_ONE :
                      ((count == CNT_MAX) ? count : count + CNT_ONE);

  // Once two bytes are held, every further byte pushes the oldest one out as payload.
  // Bytes still held when the frame ends are the CRC and are simply dropped.
  assign fwd        = accept && (state == RECV) && (count >= CNT_TWO);

  assign short_frame = (count_nxt < CNT_THREE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = din_last ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept && din_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: input is refused only while status is being presented.
  always_comb begin
    din_ready = (state != DONE);
  end

  // CRC accumulator and byte counter advance on every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_reg <= INIT;
      count   <= '0;
    end else if (accept) begin
      crc_reg <= crc_nxt;
      count   <= count_nxt;
    end
  end

  // Two-deep delay line holding the most recent accepted bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_new <= 8'h00;
      hold_old <= 8'h00;
    end else if (accept) begin
      hold_old <= hold_new;
      hold_new <= din;
    end
  end

  // Payload output: dout keeps its last value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= fwd;
      if (fwd) begin
        dout <= hold_old;
      end
    end
  end

  // End-of-frame status; verdict flags are sticky until the next frame's first byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      frame_len <= '0;
    end else if (accept && din_last) begin
      done      <= 1'b1;
      frame_len <= count_nxt;
      len_err   <= short_frame;
      crc_ok    <= !short_frame && (crc_nxt == 16'h0000);
      crc_err   <= !short_frame && (crc_nxt != 16'h0000);
    end else begin
      done <= 1'b0;
      if (accept && first_byte) begin
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
        len_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc16_par_check.sv
// Bench for crc16_par_check: frame-level reference model checked every cycle, plus directed frames.
// The model works on whole frames (byte lists, polynomial remainder of the frame), not on the RTL's registers.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_crc16_par_check;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] frame_len;

  int n_cmp = 0;
  int n_bad = 0;

  crc16_par_check #(.POLY(16'h8005), .INIT(16'h0000), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .frame_len (frame_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remainder of the whole frame, read as one long polynomial, modulo x^16+x^15+x^2+1.
  // A correctly protected frame is a multiple of the generator.
  function automatic logic [15:0] poly_mod(input bq_t q);
    logic [15:0] r;
    logic        carry;
    r = 16'h0000;
    foreach (q[k]) begin
      for (int b = 7; b >= 0; b--) begin
        carry = r[15];
        r     = {r[14:0], q[k][b]};
        if (carry) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  bq_t         m_q;
  bit          m_inframe = 0;
  bit          m_done = 0;
  logic        e_rdy = 1, e_dv = 0, e_done = 0, e_ok = 0, e_err = 0, e_len = 0;
  logic [7:0]  e_dout = 8'h00;
  int          e_flen = 0;

  initial begin
    bit acc;
    int n;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_q.delete();
        m_inframe = 0; m_done = 0;
        e_rdy = 1; e_dv = 0; e_done = 0; e_ok = 0; e_err = 0; e_len = 0;
        e_dout = 8'h00; e_flen = 0;
      end else begin
        acc    = din_valid && !m_done;
        e_dv   = 0;
        e_done = 0;
        m_done = 0;
        if (acc) begin
          if (!m_inframe) begin
            m_q.delete();
            m_inframe = 1;
            e_ok = 0; e_err = 0; e_len = 0;
          end
          m_q.push_back(din);
          if (m_q.size() >= 3) begin
            e_dv   = 1;
            e_dout = m_q[m_q.size() - 3];
          end
          if (din_last) begin
            n      = m_q.size();
            e_done = 1;
            e_flen = (n > 65535) ? 65535 : n;
            e_len  = (n < 3);
            e_ok   = !e_len && (poly_mod(m_q) == 16'h0000);
            e_err  = !e_len && (poly_mod(m_q) != 16'h0000);
            m_inframe = 0;
            m_done    = 1;
          end
        end
        e_rdy = !m_done;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("din_ready",  din_ready,  e_rdy);
      check("dout_valid", dout_valid, e_dv);
      check("dout",       dout,       e_dout);
      check("done",       done,       e_done);
      check("crc_ok",     crc_ok,     e_ok);
      check("crc_err",    crc_err,    e_err);
      check("len_err",    len_err,    e_len);
      check("frame_len",  frame_len,  e_flen);
    end
  end

  // Pulse counters observed from the DUT, for the directed checks.
  int dv_cnt = 0;
  int done_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (dout_valid) dv_cnt++;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic        st_rdy, st_done, st_ok, st_err, st_len;
  logic [15:0] st_flen;

  // Offers the frame; with gap set, din_valid drops every other cycle.
  // The cycle after the last byte is the status cycle: status is captured there,
  // and with junk set an extra last-flagged byte is offered that must be refused.
  task automatic send(input bq_t fr, input bit gap, input bit junk);
    int i = 0;
    int cyc = 0;
    while (i < fr.size()) begin
      @(negedge clk);
      if (gap && cyc[0]) begin
        din_valid = 1'b0;
        din_last  = 1'b0;
      end else begin
        din_valid = 1'b1;
        din       = fr[i];
        din_last  = (i == fr.size() - 1);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    st_rdy = din_ready; st_done = done; st_ok = crc_ok;
    st_err = crc_err;   st_len = len_err; st_flen = frame_len;
    din_valid = junk;
    din       = 8'hAA;
    din_last  = junk;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din_last  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t pass_f, cor_f, min_f, two_f, one_f, chk_f;
    int  d0, dn0;

    pass_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
    cor_f  = pass_f;
    cor_f[10] = 8'hE9;
    min_f  = '{8'h00, 8'h00, 8'h00};
    two_f  = '{8'h12, 8'h34};
    one_f  = '{8'hAB};
    chk_f  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h00, 8'h00};

    // Pin the model's arithmetic with hand-known values.
    check("model_crc_123456789", poly_mod(chk_f), 16'hFEE8);
    check("model_pass_residue",  poly_mod(pass_f), 16'h0000);
    check("model_corrupt_residue", poly_mod(cor_f), 16'h0001);

    // Reset state.
    #12;
    check("rst_din_ready", din_ready, 1'b1);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_frame_len", frame_len, 16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    idle(2);

    // Good frame.
    d0 = dv_cnt;
    send(pass_f, 0, 0);
    idle(2);
    check("pass_done", st_done, 1'b1);
    check("pass_crc_ok", st_ok, 1'b1);
    check("pass_crc_err", st_err, 1'b0);
    check("pass_frame_len", st_flen, 16'd11);
    check("pass_ready_in_done", st_rdy, 1'b0);
    check("pass_dout_pulses", dv_cnt - d0, 9);

    // Corrupted CRC.
    d0 = dv_cnt;
    send(cor_f, 0, 0);
    idle(2);
    check("corrupt_crc_err", st_err, 1'b1);
    check("corrupt_crc_ok", st_ok, 1'b0);
    check("corrupt_frame_len", st_flen, 16'd11);
    check("corrupt_dout_pulses", dv_cnt - d0, 9);

    // Minimum-length frame.
    d0 = dv_cnt;
    send(min_f, 0, 0);
    idle(2);
    check("min_crc_ok", st_ok, 1'b1);
    check("min_frame_len", st_flen, 16'd3);
    check("min_dout_pulses", dv_cnt - d0, 1);
    check("min_dout_value", dout, 8'h00);

    // Two-byte frame.
    d0 = dv_cnt;
    send(two_f, 0, 0);
    idle(2);
    check("two_len_err", st_len, 1'b1);
    check("two_crc_ok", st_ok, 1'b0);
    check("two_frame_len", st_flen, 16'd2);
    check("two_dout_pulses", dv_cnt - d0, 0);

    // Single byte, last in IDLE.
    send(one_f, 0, 0);
    idle(2);
    check("one_done", st_done, 1'b1);
    check("one_len_err", st_len, 1'b1);
    check("one_frame_len", st_flen, 16'd1);

    // Gapped frame then back-to-back frame; a byte offered in each status cycle is refused.
    d0 = dv_cnt;
    send(pass_f, 1, 1);
    check("b2b1_crc_ok", st_ok, 1'b1);
    check("b2b1_ready_in_done", st_rdy, 1'b0);
    send(pass_f, 0, 1);
    idle(3);
    check("b2b2_crc_ok", st_ok, 1'b1);
    check("b2b2_frame_len", st_flen, 16'd11);
    check("b2b_dout_pulses", dv_cnt - d0, 18);
    check("b2b_idle_after", crc_ok, 1'b1);

    // Reset in the middle of a frame.
    dn0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = pass_f[i];
      din_last  = 1'b0;
    end
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_dout_valid", dout_valid, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_crc_ok", crc_ok, 1'b0);
    check("arst_frame_len", frame_len, 16'd0);
    check("arst_din_ready", din_ready, 1'b1);
    idle(2);
    #2 rst = 1'b1;
    idle(2);
    check("arst_no_done", done_cnt - dn0, 0);
    send(pass_f, 0, 0);
    idle(2);
    check("after_rst_crc_ok", st_ok, 1'b1);
    check("after_rst_frame_len", st_flen, 16'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc16_par_check.md
Name: crc16_par_check

Overview:
- Byte-parallel CRC-16 checker for the receive side of our CRC-16 framed byte link.
- Accepts a frame of payload bytes followed by a 2-byte CRC, sent high byte first.
- Forwards the payload with the CRC bytes stripped.
- Reports pass/fail, length error and frame length at end of frame.

Parameters:
- POLY, 16'h8005, generator polynomial x^16+x^15+x^2+1 (MSB-first, non-reflected).
- INIT, 16'h0000, CRC register value loaded at start of each frame.
- CNT_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  8  received byte, bit 7 processed first.
- din_valid  in  1  din is valid this cycle.
- din_last  in  1  qualifies din as the final byte of the frame (low CRC byte).
- din_ready  out  1  checker can accept a byte.
- dout  out  8  forwarded payload byte.
- dout_valid  out  1  dout is valid this cycle.
- done  out  1  one-cycle pulse: status outputs are valid.
- crc_ok  out  1  frame passed.
- crc_err  out  1  residue nonzero.
- len_err  out  1  frame shorter than 3 bytes.
- frame_len  out  CNT_W  bytes accepted in the last frame, CRC bytes included.

Behaviour:
- Reset (rst=0, async): state=IDLE, crc_reg=INIT, count=0.
- Reset values of outputs: dout=0, dout_valid=0, done=0, crc_ok=0, crc_err=0, len_err=0, frame_len=0, din_ready=1. Reset mid-frame discards the frame silently: no done pulse.
- Accept condition: a byte is accepted when din_valid && din_ready. din_ready=1 in IDLE and RECV, 0 in DONE.
- FSM:
  - IDLE -> RECV on an accepted byte with din_last=0.
  - IDLE -> DONE on an accepted byte with din_last=1.
  - RECV stays in RECV while accepted bytes have din_last=0 or din_valid=0.
  - RECV -> DONE on an accepted byte with din_last=1.
  - DONE -> IDLE unconditionally after one cycle.
- CRC update:
  - On each accepted byte, crc_reg <= next_crc(crc_reg, din): 8 serial MSB-first LFSR steps collapsed into one combinational stage.
  - For the first byte of a frame (accepted in IDLE), crc_reg is treated as INIT.
  - The CRC bytes are run through the same update. A correct frame leaves a residue of 16'h0000.
- Counter: count increments on each accepted byte and saturates at 2^CNT_W-1. It restarts at 1 on the first byte of a new frame.
- Payload strip:
  - A 2-entry byte delay line holds the last two accepted bytes.
  - When a third or later byte is accepted, the oldest held byte is driven on dout with dout_valid=1 in the next cycle. This gives 1-cycle latency from acceptance of byte n+2 to output of byte n.
  - The 2 held bytes at din_last are the CRC and are discarded; they are never output.
  - dout_valid=0 in all other cycles. dout holds its last value.
- Status, registered in the cycle after the din_last byte is accepted (state DONE):
  - done=1 for exactly that cycle.
  - frame_len = final count.
  - len_err = (frame_len < 3).
  - crc_err = !len_err && (residue != 0).
  - crc_ok = !len_err && (residue == 0).
  - crc_ok, crc_err and len_err are mutually exclusive.
  - They hold until the next frame's first accepted byte clears them, or until reset.
- Simultaneous events:
  - din_valid in DONE is ignored, because din_ready=0.
  - din_last is ignored when din_valid=0.
  - A new frame may start in the cycle after DONE.
- Width: crc_reg is 16 bits and all arithmetic is XOR. The counter has no wrap.

Test Plan:
- Pass: send 31 32 33 34 35 36 37 38 39 FE E8, last on E8 -> dout 31..39, nine pulses; done one cycle after E8; crc_ok=1; frame_len=11.
- Corrupt CRC: same frame ending FE E9 -> crc_err=1, crc_ok=0; payload still forwarded; frame_len=11.
- Minimum and short frames:
  - 00 00 00 -> crc_ok=1, one dout of 00.
  - 12 34 with last on 34 -> len_err=1, no dout_valid.
  - Single byte with din_last in IDLE -> len_err=1, frame_len=1.
- Back-to-back with gaps: the pass frame with din_valid dropped every other cycle, then a second pass frame starting the cycle after done -> both crc_ok; din_ready=0 only in each DONE cycle; a byte offered during DONE is not accepted.
- Reset mid-frame: assert rst after 31 32 33 -> all outputs 0 asynchronously, no done pulse. Next full pass frame -> crc_ok=1, frame_len=11.
